// File: rtl/vrf_xor_mport_if.sv
// Read/write port bundle for vrf_xor_mport: R read ports, W byte-masked write ports.
interface vrf_xor_mport_if #(
  parameter int unsigned R_PORTS_NUM = 8,
  parameter int unsigned W_PORTS_NUM = 4,
  parameter int unsigned MEM_DEPTH   = 512,
  parameter int unsigned MEM_WIDTH   = 32
);
  localparam int unsigned AW = $clog2(MEM_DEPTH);
  localparam int unsigned NB = MEM_WIDTH / 8;

  logic [R_PORTS_NUM-1:0][AW-1:0]        raddr_i;
  logic [R_PORTS_NUM-1:0]                ren_i;
  logic [R_PORTS_NUM-1:0][MEM_WIDTH-1:0] dout_o;
  logic [R_PORTS_NUM-1:0]                dvalid_o;
  logic [W_PORTS_NUM-1:0][AW-1:0]        waddr_i;
  logic [W_PORTS_NUM-1:0][NB-1:0]        bwe_i;
  logic [W_PORTS_NUM-1:0]                wen_i;
  logic [W_PORTS_NUM-1:0][MEM_WIDTH-1:0] din_i;
  logic                                  wr_collision_o;

  modport master (
    output raddr_i, ren_i, waddr_i, bwe_i, wen_i, din_i,
    input  dout_o, dvalid_o, wr_collision_o
  );
  modport slave (
    input  raddr_i, ren_i, waddr_i, bwe_i, wen_i, din_i,
    output dout_o, dvalid_o, wr_collision_o
  );
endinterface

// File: rtl/vrf_xor_mport.sv
// XOR-encoded multi-port vector register file: one bank per write port, word = XOR of banks.
// Optional read-after-write bypass enabled by defining VRF_BYPASS_EN.
module vrf_xor_mport #(
  parameter int unsigned R_PORTS_NUM  = 8,
  parameter int unsigned W_PORTS_NUM  = 4,
  parameter int unsigned MEM_DEPTH    = 512,
  parameter int unsigned MEM_WIDTH    = 32,
  parameter int unsigned READ_LATENCY = 1
) (
  input logic             clk,
  input logic             rstn,
  vrf_xor_mport_if.slave  bus
);
  localparam int unsigned AW = $clog2(MEM_DEPTH);
  localparam int unsigned NB = MEM_WIDTH / 8;
  localparam int unsigned R  = R_PORTS_NUM;
  localparam int unsigned W  = W_PORTS_NUM;

  typedef logic [MEM_WIDTH-1:0] word_t;

  function automatic word_t merge(word_t base, logic [NB-1:0] mask, word_t upd);
    word_t r = base;
    for (int unsigned k = 0; k < NB; k++) begin
      if (mask[k]) r[8*k +: 8] = upd[8*k +: 8];
    end
    return r;
  endfunction

  // Every read/encode copy of a bank holds identical content; one array models all copies.
  word_t bank_q [W][MEM_DEPTH];

  logic [W-1:0]          wvld, wdrop, wacc;
  logic [W-1:0]          s1_vld_q;
  logic [W-1:0][AW-1:0]  s1_addr_q;
  logic [W-1:0][NB-1:0]  s1_bwe_q;
  word_t                 s1_din_q [W];
  word_t                 s1_enc [W];
  word_t                 enc_rd_d [W][W];
  word_t                 enc_rd_q [W][W];
  logic                  col_q;
  word_t                 rd_raw_d [R];
  word_t                 rd_raw_q [R];
  word_t                 dout1 [R];
  logic [R-1:0]          rd_vld_q;
`ifdef VRF_BYPASS_EN
  logic [NB-1:0]         byp_mask_d [R];
  logic [NB-1:0]         byp_mask_q [R];
  word_t                 byp_data_d [R];
  word_t                 byp_data_q [R];
`endif

  // Lower-numbered port wins an overlapping same-address clash.
  always_comb begin
    wdrop = '0;
    for (int unsigned q = 0; q < W; q++) wvld[q] = bus.wen_i[q] & (|bus.bwe_i[q]);
    for (int unsigned q = 0; q < W; q++) begin
      for (int unsigned p = 0; p < q; p++) begin
        if (wvld[p] && wvld[q] && (bus.waddr_i[p] == bus.waddr_i[q]) &&
            (|(bus.bwe_i[p] & bus.bwe_i[q]))) wdrop[q] = 1'b1;
      end
    end
  end
  assign wacc = wvld & ~wdrop;

  always_comb begin
    for (int unsigned p = 0; p < W; p++) begin
      s1_enc[p] = s1_din_q[p];
      for (int unsigned b = 0; b < W; b++) begin
        if (b != p) s1_enc[p] = s1_enc[p] ^ enc_rd_q[p][b];
      end
    end
  end

  // S0 encode reads see this cycle's S1 commit to the same bank/address.
  always_comb begin
    for (int unsigned p = 0; p < W; p++) begin
      for (int unsigned b = 0; b < W; b++) begin
        if (b == p) begin
          enc_rd_d[p][b] = '0;
        end else begin
          enc_rd_d[p][b] = merge(bank_q[b][bus.waddr_i[p]],
                                 (s1_vld_q[b] && (s1_addr_q[b] == bus.waddr_i[p])) ?
                                 s1_bwe_q[b] : '0,
                                 s1_enc[b]);
        end
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < R; i++) begin
      rd_raw_d[i] = '0;
      for (int unsigned b = 0; b < W; b++) rd_raw_d[i] = rd_raw_d[i] ^ bank_q[b][bus.raddr_i[i]];
`ifdef VRF_BYPASS_EN
      byp_mask_d[i] = '0;
      byp_data_d[i] = '0;
      for (int unsigned p = 0; p < W; p++) begin
        if (s1_vld_q[p] && (s1_addr_q[p] == bus.raddr_i[i])) begin
          byp_mask_d[i] = byp_mask_d[i] | s1_bwe_q[p];
          byp_data_d[i] = merge(byp_data_d[i], s1_bwe_q[p], s1_din_q[p]);
        end
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned p = 0; p < W; p++) begin
      if (rstn && s1_vld_q[p]) begin
        for (int unsigned k = 0; k < NB; k++) begin
          if (s1_bwe_q[p][k]) bank_q[p][s1_addr_q[p]][8*k +: 8] <= s1_enc[p][8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_vld_q <= '0;
      col_q    <= 1'b0;
      rd_vld_q <= '0;
      for (int unsigned i = 0; i < R; i++) begin
        rd_raw_q[i] <= '0;
`ifdef VRF_BYPASS_EN
        byp_mask_q[i] <= '0;
        byp_data_q[i] <= '0;
`endif
      end
    end else begin
      s1_vld_q <= wacc;
      col_q    <= |wdrop;
      rd_vld_q <= bus.ren_i;
      for (int unsigned i = 0; i < R; i++) begin
        if (bus.ren_i[i]) begin
          rd_raw_q[i] <= rd_raw_d[i];
`ifdef VRF_BYPASS_EN
          byp_mask_q[i] <= byp_mask_d[i];
          byp_data_q[i] <= byp_data_d[i];
`endif
        end
      end
    end
    s1_addr_q <= bus.waddr_i;
    s1_bwe_q  <= bus.bwe_i;
    for (int unsigned p = 0; p < W; p++) begin
      s1_din_q[p] <= bus.din_i[p];
      for (int unsigned b = 0; b < W; b++) enc_rd_q[p][b] <= enc_rd_d[p][b];
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < R; i++) begin
`ifdef VRF_BYPASS_EN
      dout1[i] = merge(rd_raw_q[i], byp_mask_q[i], byp_data_q[i]);
`else
      dout1[i] = rd_raw_q[i];
`endif
    end
  end

  assign bus.wr_collision_o = col_q;

  if (READ_LATENCY == 2) begin : g_lat2
    word_t        dout2_q [R];
    logic [R-1:0] dvalid2_q;
    always_ff @(posedge clk) begin
      if (!rstn) begin
        dvalid2_q <= '0;
        for (int unsigned i = 0; i < R; i++) dout2_q[i] <= '0;
      end else begin
        dvalid2_q <= rd_vld_q;
        for (int unsigned i = 0; i < R; i++) begin
          if (rd_vld_q[i]) dout2_q[i] <= dout1[i];
        end
      end
    end
    always_comb begin
      for (int unsigned i = 0; i < R; i++) bus.dout_o[i] = dout2_q[i];
    end
    assign bus.dvalid_o = dvalid2_q;
  end else begin : g_lat1
    always_comb begin
      for (int unsigned i = 0; i < R; i++) bus.dout_o[i] = dout1[i];
    end
    assign bus.dvalid_o = rd_vld_q;
  end
endmodule
